// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters, the consumer and alu_arbiter
// Operand and result fields carry two's-complement bit patterns; signedness is applied inside the ALU.
interface alu_arbiter_if #(
  parameter int W = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_opcode;
  logic         req0_op1;
  logic [1:0]   req0_op2;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_opcode;
  logic         req1_op1;
  logic [1:0]   req1_op2;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W:0]   rsp_y;
  logic [W-1:0] rsp_y1;
  logic [7:0]   ops_done;

  // Requester/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_opcode, req0_op1, req0_op2,
    output req1_valid, req1_a, req1_b, req1_opcode, req1_op1, req1_op2,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_y1, ops_done
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opcode, req0_op1, req0_op2,
    input  req1_valid, req1_a, req1_b, req1_opcode, req1_op1, req1_op2,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_y1, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one registered add/sub/logic ALU between two requesters
// Transaction flow: IDLE grants and latches operands, EXEC computes, RESP holds the result until taken.
module alu_arbiter #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic         last_grant;
  logic         grant;
  logic         any_valid;
  logic         take;
  logic         rsp_done;

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         opcode_q;
  logic         op1_q;
  logic [1:0]   op2_q;
  logic         id_q;

  logic [W:0]   y_q;
  logic [W-1:0] y1_q;
  logic [7:0]   ops_q;

  logic [W:0]   a_ext;
  logic [W:0]   b_ext;
  logic [W:0]   arith;
  logic [W-1:0] logic_res;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = bus.req1_valid;
    end
  end

  assign take     = (state == IDLE) && any_valid;
  assign rsp_done = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = any_valid && !grant;
        bus.req1_ready = any_valid && grant;
      end
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Sign-extend to W+1 bits so add/sub never overflows the result field.
  always_comb begin
    a_ext = {a_q[W-1], a_q};
    b_ext = {b_q[W-1], b_q};
    arith = op1_q ? (a_ext - b_ext) : (a_ext + b_ext);
    case (op2_q)
      2'b00:   logic_res = ~a_q;
      2'b01:   logic_res = ~b_q;
      2'b10:   logic_res = a_q & b_q;
      default: logic_res = a_q | b_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      opcode_q   <= 1'b0;
      op1_q      <= 1'b0;
      op2_q      <= 2'b00;
      id_q       <= 1'b0;
      y_q        <= '0;
      y1_q       <= '0;
      ops_q      <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      if (take) begin
        id_q <= grant;
        if (grant) begin
          a_q      <= bus.req1_a;
          b_q      <= bus.req1_b;
          opcode_q <= bus.req1_opcode;
          op1_q    <= bus.req1_op1;
          op2_q    <= bus.req1_op2;
        end else begin
          a_q      <= bus.req0_a;
          b_q      <= bus.req0_b;
          opcode_q <= bus.req0_opcode;
          op1_q    <= bus.req0_op1;
          op2_q    <= bus.req0_op2;
        end
      end
      if (state == EXEC) begin
        if (opcode_q) begin
          y_q  <= arith;
          y1_q <= '0;
        end else begin
          y_q  <= '0;
          y1_q <= logic_res;
        end
      end
      if (rsp_done) begin
        last_grant <= id_q;
        ops_q      <= ops_q + 8'd1;
      end
    end
  end

  assign bus.rsp_id   = id_q;
  assign bus.rsp_y    = y_q;
  assign bus.rsp_y1   = y1_q;
  assign bus.ops_done = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter
module tb_alu_arbiter;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.W(8)) bus ();

  alu_arbiter #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic       opcode;
    logic       op1;
    logic [1:0] op2;
    logic [8:0] exp_y;
    logic [7:0] exp_y1;
  } vec_t;

  vec_t vecs[9];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_ops = 8'd0;
  logic       exp_last = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic valid, input logic [7:0] a, input logic [7:0] b,
                           input logic opcode, input logic op1, input logic [1:0] op2);
    if (id) begin
      bus.req1_valid = valid; bus.req1_a = a; bus.req1_b = b;
      bus.req1_opcode = opcode; bus.req1_op1 = op1; bus.req1_op2 = op2;
    end else begin
      bus.req0_valid = valid; bus.req0_a = a; bus.req0_b = b;
      bus.req0_opcode = opcode; bus.req0_op1 = op1; bus.req0_op2 = op2;
    end
  endtask

  function automatic logic ready_of(input logic id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  // Called at a negedge; waits (bounded) for the given requester's ready.
  task automatic wait_ready(input logic id, input string name);
    int n = 0;
    while (ready_of(id) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, ready_of(id)}, 32'd1);
  endtask

  // Single-requester transaction from the vector table, rsp_ready held high.
  task automatic run_vec(input int idx);
    vec_t v = vecs[idx];
    drive_req(v.id, 1'b1, v.a, v.b, v.opcode, v.op1, v.op2);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d ready_now", idx), {31'd0, ready_of(v.id)}, 32'd1);
    wait_ready(v.id, $sformatf("v%0d ready", idx));
    @(posedge clk); #1;
    drive_req(v.id, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    chk($sformatf("v%0d exec_valid", idx), {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d rsp_valid", idx), {31'd0, bus.rsp_valid}, 32'd1);
    chk($sformatf("v%0d rsp_id", idx), {31'd0, bus.rsp_id}, {31'd0, v.id});
    chk($sformatf("v%0d rsp_y", idx), {23'd0, bus.rsp_y}, {23'd0, v.exp_y});
    chk($sformatf("v%0d rsp_y1", idx), {24'd0, bus.rsp_y1}, {24'd0, v.exp_y1});
    @(posedge clk); #1;
    exp_ops++;
    exp_last = v.id;
    chk($sformatf("v%0d ops_done", idx), {24'd0, bus.ops_done}, {24'd0, exp_ops});
    chk($sformatf("v%0d idle_valid", idx), {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd5,    8'd6,    1'b1, 1'b0, 2'b00, 9'h00B, 8'h00};
    vecs[1] = '{1'b1, 8'hF8,   8'hF7,   1'b1, 1'b1, 2'b00, 9'h001, 8'h00};
    vecs[2] = '{1'b1, 8'hFF,   8'd9,    1'b1, 1'b1, 2'b00, 9'h1F6, 8'h00};
    vecs[3] = '{1'b0, 8'h02,   8'h07,   1'b0, 1'b0, 2'b10, 9'h000, 8'h02};
    vecs[4] = '{1'b1, 8'd28,   8'd0,    1'b0, 1'b1, 2'b00, 9'h000, 8'hE3};
    vecs[5] = '{1'b0, 8'd0,    8'd25,   1'b0, 1'b0, 2'b01, 9'h000, 8'hE6};
    vecs[6] = '{1'b1, 8'd5,    8'd3,    1'b0, 1'b0, 2'b11, 9'h000, 8'h07};
    vecs[7] = '{1'b0, 8'd127,  8'd127,  1'b1, 1'b0, 2'b00, 9'h0FE, 8'h00};
    vecs[8] = '{1'b1, 8'h80,   8'd127,  1'b1, 1'b1, 2'b00, 9'h101, 8'h00};

    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    chk("rst req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("rst rsp_y", {23'd0, bus.rsp_y}, 32'd0);
    chk("rst rsp_y1", {24'd0, bus.rsp_y1}, 32'd0);
    chk("rst ops_done", {24'd0, bus.ops_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Round-robin with both requesters valid continuously.
    drive_req(1'b0, 1'b1, 8'd1,  8'd2, 1'b1, 1'b0, 2'b00);
    drive_req(1'b1, 1'b1, 8'd10, 8'd3, 1'b1, 1'b1, 2'b00);
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      logic exp_id;
      exp_id = ~exp_last;
      chk($sformatf("rr%0d expected_order", t), {31'd0, exp_id}, {31'd0, t[0]});
      @(negedge clk);
      wait_ready(exp_id, $sformatf("rr%0d winner_ready", t));
      chk($sformatf("rr%0d loser_ready", t), {31'd0, ready_of(~exp_id)}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d exec_ready0", t), {31'd0, bus.req0_ready}, 32'd0);
      chk($sformatf("rr%0d exec_ready1", t), {31'd0, bus.req1_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("rr%0d rsp_valid", t), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("rr%0d rsp_id", t), {31'd0, bus.rsp_id}, {31'd0, exp_id});
      chk($sformatf("rr%0d rsp_y", t), {23'd0, bus.rsp_y}, exp_id ? 32'h007 : 32'h003);
      @(posedge clk); #1;
      exp_ops++;
      exp_last = exp_id;
    end
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    chk("rr ops_done", {24'd0, bus.ops_done}, {24'd0, exp_ops});

    // Back-pressure: RESP held for 10 cycles while both requesters wait.
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 8'd127, 8'd127, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    wait_ready(1'b0, "bp ready");
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", c), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("bp%0d rsp_y", c), {23'd0, bus.rsp_y}, 32'h0FE);
      chk($sformatf("bp%0d ready0", c), {31'd0, bus.req0_ready}, 32'd0);
      chk($sformatf("bp%0d ready1", c), {31'd0, bus.req1_ready}, 32'd0);
    end
    chk("bp ops_held", {24'd0, bus.ops_done}, {24'd0, exp_ops});
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops++;
    exp_last = 1'b0;
    chk("bp release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp ops_done", {24'd0, bus.ops_done}, {24'd0, exp_ops});

    // 256 back-to-back transactions: ops_done wraps back to its starting value.
    begin
      int count = 0;
      int cycles = 0;
      drive_req(1'b0, 1'b1, 8'd3, 8'd4, 1'b1, 1'b0, 2'b00);
      while (count < 256 && cycles < 2000) begin
        @(negedge clk);
        cycles++;
        if (bus.rsp_valid === 1'b1) begin
          count++;
          if (count == 255) begin
            chk("wrap ops_255", {24'd0, bus.ops_done}, {24'd0, 8'(exp_ops + 8'd254)});
          end
        end
      end
      chk("wrap count", count, 32'd256);
      chk("wrap min_cycles", {31'd0, cycles >= 768}, 32'd1);
      drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
      @(posedge clk); #1;
      chk("wrap ops_done", {24'd0, bus.ops_done}, {24'd0, exp_ops});
    end

    // Reset during EXEC discards the transaction.
    drive_req(1'b0, 1'b1, 8'd5, 8'd6, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    wait_ready(1'b0, "mid ready");
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("mid rsp_y", {23'd0, bus.rsp_y}, 32'd0);
    chk("mid rsp_y1", {24'd0, bus.rsp_y1}, 32'd0);
    chk("mid ops_done", {24'd0, bus.ops_done}, 32'd0);
    chk("mid ready0", {31'd0, bus.req0_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post%0d rsp_valid", c), {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0, 2'b00);
    drive_req(1'b1, 1'b1, 8'd2, 8'd2, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    chk("post tie ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("post tie ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("post ops_done", {24'd0, bus.ops_done}, 32'd0);
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
